// File: rtl/k12a_regfile.sv
// k12a_regfile: four 8-bit CPU registers (A, B, C, D) sharing a tristate data
// bus, with an A/B exchange, a latched ALU condition flag and a sticky flag
// for illegal control combinations.
module k12a_regfile #(
    parameter logic [7:0] RESET_VALUE = 8'h00
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       a_store,
    input  logic       b_store,
    input  logic       c_store,
    input  logic       d_store,
    input  logic       swap_ab,
    input  logic       reg_load,
    input  logic [1:0] reg_load_sel,
    input  logic       cond_store,
    input  logic       alu_condition,
    inout  wire  [7:0] data_bus,
    output logic [7:0] a,
    output logic [7:0] b,
    output logic [7:0] c,
    output logic [7:0] d,
    output logic       cond,
    output logic       bus_error
);

    // Register file: index 0=A, 1=B, 2=C, 3=D (same order as reg_load_sel).
    logic [7:0] regs_reg  [4];
    logic [7:0] regs_next [4];
    logic [3:0] store;
    logic [7:0] sel_val;
    logic [7:0] bus_val;
    logic       bus_floating;
    logic       cond_reg;
    logic       cond_next;
    logic       bus_error_reg;
    logic       bus_error_next;

    assign store = {d_store, c_store, b_store, a_store};

    // The selected register drives the bus combinationally, regardless of reset.
    assign sel_val  = regs_reg[reg_load_sel];
    assign data_bus = reg_load ? sel_val : 8'hzz;

    // Stores always sample the resolved bus, so a load+store in one cycle is a
    // single-cycle register-to-register move.
    assign bus_val = data_bus;

    // An undriven bus can only be detected in simulation; hardware has no way
    // to see a floating net, so the term is constant there.
`ifdef SYNTHESIS
    assign bus_floating = 1'b0;
`else
    assign bus_floating = $isunknown(data_bus);
`endif

    // Next-state per register: a store wins; otherwise A/B take each other's
    // old value on swap. When only one of A/B is stored during a swap, the
    // other still receives the stored register's old value.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_next
            if (gi < 2) begin : g_swappable
                always_comb begin
                    regs_next[gi] = regs_reg[gi];
                    if (store[gi]) begin
                        regs_next[gi] = bus_val;
                    end else if (swap_ab) begin
                        regs_next[gi] = regs_reg[1 - gi];
                    end
                end
            end else begin : g_plain
                always_comb begin
                    regs_next[gi] = regs_reg[gi];
                    if (store[gi]) begin
                        regs_next[gi] = bus_val;
                    end
                end
            end
        end
    endgenerate

    // Condition flag and sticky error next-state.
    always_comb begin
        cond_next      = cond_store ? alu_condition : cond_reg;
        bus_error_next = bus_error_reg
                       | (swap_ab & a_store & b_store)
                       | ((|store) & ~reg_load & bus_floating);
    end

    // Register update with synchronous active-low reset taking priority.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) begin
                regs_reg[i] <= RESET_VALUE;
            end
            cond_reg      <= 1'b0;
            bus_error_reg <= 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                regs_reg[i] <= regs_next[i];
            end
            cond_reg      <= cond_next;
            bus_error_reg <= bus_error_next;
        end
    end

    assign a         = regs_reg[0];
    assign b         = regs_reg[1];
    assign c         = regs_reg[2];
    assign d         = regs_reg[3];
    assign cond      = cond_reg;
    assign bus_error = bus_error_reg;

endmodule

// File: doc/k12a_regfile.md
K12A_REGFILE -- requirements
Module: k12a_regfile

Interface
REQ-001 Parameter: RESET_VALUE, 8'h00, value loaded into A, B, C and D at reset.
REQ-002 One clock; reset is synchronous and active-low. Ports are named clock and reset_n.
REQ-003 clock  input  1  rising-edge clock for all state.
REQ-004 reset_n  input  1  synchronous active-low reset.
REQ-005 a_store, b_store, c_store, d_store  input  1 each  capture data_bus into A, B, C or D at the next edge.
REQ-006 swap_ab  input  1  exchange A and B at the next edge.
REQ-007 reg_load  input  1  drive the selected register onto data_bus.
REQ-008 reg_load_sel  input  2  register select for reg_load: 0=A, 1=B, 2=C, 3=D.
REQ-009 cond_store  input  1  capture alu_condition into COND at the next edge.
REQ-010 alu_condition  input  1  condition bit from the ALU.
REQ-011 data_bus  inout  8  shared CPU data bus.
REQ-012 a, b  output  8 each  current A and B, feeding the ALU operand inputs.
REQ-013 c, d  output  8 each  current C and D.
REQ-014 cond  output  1  latched condition flag.
REQ-015 bus_error  output  1  sticky flag marking an illegal control combination.

Function
REQ-016 A, B, C and D SHALL each be 8-bit registers updated only on the rising edge of clock; outputs a, b, c and d SHALL be the register values directly, with no combinational bypass.
REQ-017 data_bus SHALL carry the selected register while reg_load=1 and SHALL be 8'hzz otherwise; this drive is combinational and the same cycle as reg_load.
REQ-018 For reg_load=1 together with any x_store=1: the stored register SHALL capture the value on data_bus.
  - That value is the register's own pre-edge value, or another register's (e.g. C<=A).
  - Data moves register-to-register in one cycle.
REQ-019 For swap_ab=1 with a_store=0 and b_store=0: A SHALL take old B and B SHALL take old A in the same edge.
REQ-020 For swap_ab=1 with a_store=1 or b_store=1: the store SHALL take priority for that register. The other of A/B SHALL take the pre-edge value of the stored register.
  - Example: swap_ab=1 and a_store=1 give A<=data_bus, B<=old A.
REQ-021 Multiple x_store strobes asserted together SHALL all capture the same data_bus value.
REQ-022 When cond_store=1, COND SHALL take alu_condition at the edge. Otherwise COND SHALL hold.
REQ-023 bus_error SHALL set at the edge following any of these cycles, and SHALL remain set until reset:
  - swap_ab=1 with both a_store=1 and b_store=1;
  - any x_store=1 with reg_load=0 and data_bus not fully driven (any bit z or x, simulation check only; synthesis ties this term to 0).
REQ-024 A cycle that raises bus_error SHALL still perform all register updates per REQ-018..REQ-021.
REQ-025 With no strobes asserted, all state SHALL hold indefinitely.

Reset
REQ-026 When reset_n=0 at a rising edge:
  - A, B, C and D SHALL load RESET_VALUE;
  - cond and bus_error SHALL load 0.
REQ-027 Reset SHALL take priority over every strobe in the same cycle.
REQ-028 data_bus drive SHALL still follow reg_load during reset; it is combinational and independent of reset_n.
REQ-029 The first edge with reset_n=1 SHALL act on the strobes of that cycle normally.

Verification
REQ-030 Reset, then drive data_bus=8'h5A with a_store=1, then reg_load=1, reg_load_sel=0 -> a=8'h5A; data_bus reads 8'h5A in the reg_load cycle and 8'hzz afterwards.
REQ-031 A=8'h11, B=8'h22, swap_ab=1 for one cycle -> a=8'h22, b=8'h11; a second swap restores the original values.
REQ-032 A=8'h33, reg_load=1, reg_load_sel=0, c_store=1, d_store=1 -> c=8'h33, d=8'h33, a unchanged.
REQ-033 A=8'h01, B=8'h02, swap_ab=1, b_store=1, data_bus=8'hF0 -> a=8'h02, b=8'hF0, bus_error stays 0. Then swap_ab=1, a_store=1, b_store=1 -> bus_error=1 and held for 10 idle cycles.
REQ-034 alu_condition=1 with cond_store=1 -> cond=1. alu_condition=0 with cond_store=0 -> cond stays 1.
REQ-035 Mid-sequence reset_n=0 asserted together with a_store=1 -> a=RESET_VALUE, cond=0, bus_error=0. Repeat with parameter RESET_VALUE=8'hA5 -> a, b, c and d all read 8'hA5.
